// File: rtl/trap_sequencer.sv
// trap_sequencer: serialises exception, interrupt and MRET events into a
// drain -> flush -> CSR commit -> fetch redirect sequence.
// Optional feature macro: TRAP_SEQUENCER_VECTORED_EN enables vectored
// interrupt targets when mtvec[1:0] == 2'b01. The default build uses
// direct mode only.
module trap_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [63:0] exc_cause,
  input  logic [63:0] exc_pc,
  input  logic        irq_pending,
  input  logic [63:0] irq_cause,
  input  logic [63:0] irq_pc,
  input  logic        mret_valid,
  input  logic        mem_busy,
  input  logic        flush_ack,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepc,
  output logic        stall,
  output logic        flush_req,
  output logic        trap_we,
  output logic [63:0] trap_cause,
  output logic [63:0] trap_epc,
  output logic        mret_we,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH,
    S_COMMIT,
    S_REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    K_EXC,
    K_IRQ,
    K_MRET
  } kind_t;

  state_t      state_q;
  kind_t       kind_q;
  logic [63:0] cause_q;
  logic [63:0] epc_q;
  logic        stall_q;
  logic        flush_q;
  logic        trap_we_q;
  logic        mret_we_q;
  logic [63:0] trap_cause_q;
  logic [63:0] trap_epc_q;
  logic        redir_q;
  logic [63:0] redirect_pc_d;

  // Sequencer FSM: every output is registered on the transition into the
  // state that owns it, so outputs line up exactly with the current state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      kind_q       <= K_EXC;
      cause_q      <= '0;
      epc_q        <= '0;
      stall_q      <= 1'b0;
      flush_q      <= 1'b0;
      trap_we_q    <= 1'b0;
      mret_we_q    <= 1'b0;
      trap_cause_q <= '0;
      trap_epc_q   <= '0;
      redir_q      <= 1'b0;
    end else begin
      // Strobes and the trap payload are single-cycle; default them low.
      trap_we_q    <= 1'b0;
      mret_we_q    <= 1'b0;
      trap_cause_q <= '0;
      trap_epc_q   <= '0;
      redir_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Fixed priority; losing events in the same cycle are dropped.
          if (exc_valid) begin
            kind_q  <= K_EXC;
            cause_q <= exc_cause;
            epc_q   <= exc_pc;
            state_q <= S_DRAIN;
            stall_q <= 1'b1;
          end else if (irq_pending) begin
            kind_q  <= K_IRQ;
            cause_q <= irq_cause;
            epc_q   <= irq_pc;
            state_q <= S_DRAIN;
            stall_q <= 1'b1;
          end else if (mret_valid) begin
            // MRET leaves the latched cause untouched; epc is not used.
            kind_q  <= K_MRET;
            state_q <= S_DRAIN;
            stall_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!mem_busy) begin
            state_q <= S_FLUSH;
            flush_q <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_ack) begin
            state_q <= S_COMMIT;
            flush_q <= 1'b0;
            if (kind_q == K_MRET) begin
              mret_we_q <= 1'b1;
            end else begin
              trap_we_q    <= 1'b1;
              trap_cause_q <= cause_q;
              trap_epc_q   <= epc_q;
            end
          end
        end
        S_COMMIT: begin
          state_q <= S_REDIRECT;
          redir_q <= 1'b1;
        end
        S_REDIRECT: begin
          state_q <= S_IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          stall_q <= 1'b0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

`ifndef TRAP_SEQUENCER_VECTORED_EN
  // The mode bits only matter for vectored interrupts.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];
`endif

  // Redirect target is formed combinationally during REDIRECT so that an
  // MRET sees mepc after the CSR file has processed the commit strobe.
  always_comb begin
    redirect_pc_d = '0;
    if (state_q == S_REDIRECT) begin
      if (kind_q == K_MRET) begin
        redirect_pc_d = mepc;
      end else begin
        redirect_pc_d = {mtvec[63:2], 2'b00};
`ifdef TRAP_SEQUENCER_VECTORED_EN
        if ((kind_q == K_IRQ) && (mtvec[1:0] == 2'b01)) begin
          redirect_pc_d = {mtvec[63:2], 2'b00} + {56'd0, cause_q[5:0], 2'b00};
        end
`endif
      end
    end
  end

  assign stall          = stall_q;
  assign flush_req      = flush_q;
  assign trap_we        = trap_we_q;
  assign mret_we        = mret_we_q;
  assign trap_cause     = trap_cause_q;
  assign trap_epc       = trap_epc_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redirect_pc_d;

endmodule

// File: tb/tb_trap_sequencer.sv
// Testbench for trap_sequencer: directed events with a scoreboard of
// expected flush/commit/redirect observations checked by a monitor.
module tb_trap_sequencer;

  localparam int EV_FLUSH = 0;
  localparam int EV_TRAP  = 1;
  localparam int EV_MRET  = 2;
  localparam int EV_REDIR = 3;

`ifdef TRAP_SEQUENCER_VECTORED_EN
  localparam logic [63:0] VEC_IRQ_PC = 64'h0000_0000_8000_011C;
`else
  localparam logic [63:0] VEC_IRQ_PC = 64'h0000_0000_8000_0100;
`endif

  typedef struct {
    int          id;
    int          kind;
    int          cyc;
    logic [63:0] a;
    logic [63:0] b;
  } ev_t;

  logic        clk;
  logic        reset;
  logic        exc_valid;
  logic [63:0] exc_cause;
  logic [63:0] exc_pc;
  logic        irq_pending;
  logic [63:0] irq_cause;
  logic [63:0] irq_pc;
  logic        mret_valid;
  logic        mem_busy;
  logic        flush_ack;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic        stall;
  logic        flush_req;
  logic        trap_we;
  logic [63:0] trap_cause;
  logic [63:0] trap_epc;
  logic        mret_we;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  ev_t  q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_flush = 1'b0;

  trap_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .irq_pending    (irq_pending),
    .irq_cause      (irq_cause),
    .irq_pc         (irq_pc),
    .mret_valid     (mret_valid),
    .mem_busy       (mem_busy),
    .flush_ack      (flush_ack),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .stall          (stall),
    .flush_req      (flush_req),
    .trap_we        (trap_we),
    .trap_cause     (trap_cause),
    .trap_epc       (trap_epc),
    .mret_we        (mret_we),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int id, input int kind, input int c, input logic [63:0] a,
                      input logic [63:0] b);
    ev_t e;
    e.id = id; e.kind = kind; e.cyc = c; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  // Expected flush rise, commit strobe and redirect for one event accepted
  // in cycle k with x extra drain cycles.
  task automatic expect_seq(input int id, input int k, input int x, input int kind,
                            input logic [63:0] c, input logic [63:0] e, input logic [63:0] rpc);
    push(id, EV_FLUSH, k + 2 + x, 64'd0, 64'd0);
    push(id, kind,     k + 3 + x, c, e);
    push(id, EV_REDIR, k + 4 + x, rpc, 64'd0);
  endtask

  task automatic handle(input int kind, input logic [63:0] a, input logic [63:0] b);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event at cycle %0d: actual kind=%0d required=none", cyc, kind);
    end else begin
      e = q.pop_front();
      chk($sformatf("ev%0d_kind", e.id), 64'(kind), 64'(e.kind));
      chk($sformatf("ev%0d_cycle", e.id), 64'(cyc), 64'(e.cyc));
      chk($sformatf("ev%0d_data_a", e.id), a, e.a);
      chk($sformatf("ev%0d_data_b", e.id), b, e.b);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows an observable event.
  always @(negedge clk) begin
    chk("we_exclusive", {63'd0, trap_we & mret_we}, 64'd0);
    if (!trap_we) begin
      chk("trap_cause_idle", trap_cause, 64'd0);
      chk("trap_epc_idle", trap_epc, 64'd0);
    end
    if (flush_req && !prev_flush) handle(EV_FLUSH, 64'd0, 64'd0);
    if (trap_we) handle(EV_TRAP, trap_cause, trap_epc);
    if (mret_we) handle(EV_MRET, 64'd0, 64'd0);
    if (redirect_valid) handle(EV_REDIR, redirect_pc, 64'd0);
    prev_flush <= flush_req;
  end

  // Present one cycle of event inputs, starting just after a rising edge.
  task automatic fire(input bit e, input bit i, input bit m,
                      input logic [63:0] ec, input logic [63:0] ep,
                      input logic [63:0] ic, input logic [63:0] ip);
    chk("stall_pre_accept", {63'd0, stall}, 64'd0);
    exc_valid = e; exc_cause = ec; exc_pc = ep;
    irq_pending = i; irq_cause = ic; irq_pc = ip;
    mret_valid = m;
    @(posedge clk);
    #1;
    exc_valid = 1'b0; irq_pending = 1'b0; mret_valid = 1'b0;
  endtask

  // Stall must stay high until the redirect cycle, then drop.
  task automatic watch_stall(input int last);
    do begin
      @(negedge clk);
      chk("stall_busy", {63'd0, stall}, 64'd1);
    end while (cyc < last);
    @(negedge clk);
    chk("stall_idle", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {63'd0, stall}, 64'd0);
    chk({tag, "_flush_req"}, {63'd0, flush_req}, 64'd0);
    chk({tag, "_trap_we"}, {63'd0, trap_we}, 64'd0);
    chk({tag, "_mret_we"}, {63'd0, mret_we}, 64'd0);
    chk({tag, "_redirect_valid"}, {63'd0, redirect_valid}, 64'd0);
    chk({tag, "_trap_cause"}, trap_cause, 64'd0);
    chk({tag, "_trap_epc"}, trap_epc, 64'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 64'd0);
  endtask

  initial begin
    int k;
    reset = 1'b0;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0;
    irq_pending = 1'b0; irq_cause = '0; irq_pc = '0;
    mret_valid = 1'b0;
    mem_busy = 1'b0;
    flush_ack = 1'b1;
    mtvec = 64'h0000_0000_8000_0100;
    mepc  = 64'h0000_0000_8000_0200;

    #12;
    chk_all_zero("reset");
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Exception, no drain, immediate flush ack.
    k = cyc;
    expect_seq(1, k, 0, EV_TRAP, 64'd8, 64'h8000_0010, 64'h8000_0100);
    fire(1, 0, 0, 64'd8, 64'h8000_0010, 64'd0, 64'd0);
    watch_stall(k + 4);

    // Exception, interrupt and MRET together: only the exception commits.
    k = cyc;
    expect_seq(2, k, 0, EV_TRAP, 64'd2, 64'h8000_0020, 64'h8000_0100);
    fire(1, 1, 1, 64'd2, 64'h8000_0020, 64'h8000_0000_0000_0003, 64'h8000_0024);
    watch_stall(k + 4);

    // Interrupt with the data bus busy for five cycles after acceptance.
    k = cyc;
    expect_seq(3, k, 5, EV_TRAP, 64'h8000_0000_0000_000B, 64'h8000_0040, 64'h8000_0100);
    mem_busy = 1'b1;
    fire(0, 1, 0, 64'd0, 64'd0, 64'h8000_0000_0000_000B, 64'h8000_0040);
    fork
      begin
        repeat (5) @(posedge clk);
        #1;
        mem_busy = 1'b0;
      end
    join_none
    watch_stall(k + 9);

    // MRET: returns to mepc without a trap strobe.
    k = cyc;
    expect_seq(4, k, 0, EV_MRET, 64'd0, 64'd0, 64'h8000_0200);
    fire(0, 0, 1, 64'd0, 64'd0, 64'd0, 64'd0);
    watch_stall(k + 4);

    // Interrupt held high while busy is ignored.
    k = cyc;
    expect_seq(5, k, 0, EV_TRAP, 64'd4, 64'h8000_0030, 64'h8000_0100);
    fire(1, 0, 0, 64'd4, 64'h8000_0030, 64'd0, 64'd0);
    irq_pending = 1'b1;
    irq_cause = 64'h8000_0000_0000_0007;
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        irq_pending = 1'b0;
      end
    join_none
    watch_stall(k + 4);

    // Mode bits 01: interrupts vector only in the vectored build,
    // exceptions always go to the base.
    mtvec = 64'h0000_0000_8000_0101;
    k = cyc;
    expect_seq(6, k, 0, EV_TRAP, 64'h8000_0000_0000_0007, 64'h8000_0050, VEC_IRQ_PC);
    fire(0, 1, 0, 64'd0, 64'd0, 64'h8000_0000_0000_0007, 64'h8000_0050);
    watch_stall(k + 4);
    k = cyc;
    expect_seq(7, k, 0, EV_TRAP, 64'd7, 64'h8000_0058, 64'h8000_0100);
    fire(1, 0, 0, 64'd7, 64'h8000_0058, 64'd0, 64'd0);
    watch_stall(k + 4);
    mtvec = 64'h0000_0000_8000_0100;

    // Reset while waiting in FLUSH abandons the event with no strobe.
    flush_ack = 1'b0;
    k = cyc;
    push(8, EV_FLUSH, k + 2, 64'd0, 64'd0);
    fire(1, 0, 0, 64'd5, 64'h8000_0060, 64'd0, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("flush_wait", {63'd0, flush_req}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    flush_ack = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk_all_zero("post_reset");

    // One more exception to confirm normal operation after reset.
    k = cyc;
    expect_seq(9, k, 0, EV_TRAP, 64'd1, 64'h8000_0070, 64'h8000_0100);
    fire(1, 0, 0, 64'd1, 64'h8000_0070, 64'd0, 64'd0);
    watch_stall(k + 4);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
